// File: rtl/addr_bus_arbiter_if.sv
// Bus bundle between the address-generation requesters and the arbiter.
// The master side is the requester/memory environment; the slave side is the arbiter.
interface addr_bus_arbiter_if #(
  parameter int WID = 16
);
  logic [3:0]     req;
  logic [WID-1:0] a;
  logic [WID-1:0] b;
  logic [WID-1:0] c;
  logic [WID-1:0] d;
  logic           mem_rdy;
  logic [3:0]     grant;
  logic [1:0]     sel;
  logic [WID-1:0] addr;
  logic           mem_en;
  logic           done;
  logic           err;

  modport master (
    output req, a, b, c, d, mem_rdy,
    input  grant, sel, addr, mem_en, done, err
  );

  modport slave (
    input  req, a, b, c, d, mem_rdy,
    output grant, sel, addr, mem_en, done, err
  );
endinterface

// File: rtl/addr_bus_arbiter.sv
// Round-robin arbiter for the shared 16-bit memory address path.
// Four requesters compete for one 4:1 address mux; each grant lives until
// mem_rdy (done), the requester drops its request (abort), or TIMEOUT cycles
// pass without completion (err).
//
//   state | meaning
//   IDLE  | no grant; arbitrate among pending requests starting after r_last
//   BUSY  | one requester granted, mem_en high, timer counting toward timeout
module addr_bus_arbiter #(
  parameter int WID     = 16,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  addr_bus_arbiter_if.slave bus
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t         r_state;
  logic [3:0]     r_grant;
  logic [1:0]     r_sel;
  logic [1:0]     r_last;
  logic           r_mem_en;
  logic           r_done;
  logic           r_err;
  logic [TW-1:0]  r_timer;

  logic [1:0]     w_winner;
  logic [1:0]     w_cand;
  logic           w_any_req;
  logic [WID-1:0] w_addr;

  // Round-robin pick: scan last+4 down to last+1 so the nearest one after last wins.
  always_comb begin
    w_winner  = r_last;
    w_cand    = r_last;
    w_any_req = |bus.req;
    for (int i = 4; i >= 1; i--) begin
      w_cand = r_last + 2'(i);
      if (bus.req[w_cand]) begin
        w_winner = w_cand;
      end
    end
  end

  // Address mux follows sel with no latency; sel holds in IDLE so addr stays put.
  always_comb begin
    w_addr = bus.a;
    case (r_sel)
      2'd0:    w_addr = bus.a;
      2'd1:    w_addr = bus.b;
      2'd2:    w_addr = bus.c;
      default: w_addr = bus.d;
    endcase
  end

  // Arbitration FSM with registered grant, select, enable and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_grant  <= 4'b0000;
      r_sel    <= 2'b00;
      r_last   <= 2'd3;
      r_mem_en <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_timer  <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_grant  <= 4'b0001 << w_winner;
            r_sel    <= w_winner;
            r_mem_en <= 1'b1;
            r_timer  <= '0;
            r_state  <= BUSY;
          end
        end
        BUSY: begin
          // Completion outranks abort and timeout, so a late mem_rdy is still a success.
          if (bus.mem_rdy) begin
            r_done   <= 1'b1;
            r_grant  <= 4'b0000;
            r_mem_en <= 1'b0;
            r_last   <= r_sel;
            r_state  <= IDLE;
          end else if (!bus.req[r_sel]) begin
            r_grant  <= 4'b0000;
            r_mem_en <= 1'b0;
            r_last   <= r_sel;
            r_state  <= IDLE;
          end else if (r_timer == TIMER_LAST) begin
            r_err    <= 1'b1;
            r_grant  <= 4'b0000;
            r_mem_en <= 1'b0;
            r_last   <= r_sel;
            r_state  <= IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.grant  = r_grant;
  assign bus.sel    = r_sel;
  assign bus.addr   = w_addr;
  assign bus.mem_en = r_mem_en;
  assign bus.done   = r_done;
  assign bus.err    = r_err;

endmodule

// File: tb/tb_addr_bus_arbiter.sv
// Directed bench for addr_bus_arbiter. Inputs change and outputs are sampled
// on the falling edge; the DUT acts on the rising edge.
module tb_addr_bus_arbiter;

  localparam int WID     = 16;
  localparam int TIMEOUT = 16;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;

  addr_bus_arbiter_if #(.WID(WID)) u_if ();

  addr_bus_arbiter #(
    .WID    (WID),
    .TIMEOUT(TIMEOUT)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one full cycle: the rising edge acts, then land on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_grant"}, 32'(u_if.grant), 32'h0);
    check_eq({tag, "_mem_en"}, 32'(u_if.mem_en), 32'h0);
  endtask

  task automatic check_grant(input string tag, input int idx, input logic [15:0] exp_addr);
    check_eq({tag, "_grant"}, 32'(u_if.grant), 32'(4'b0001 << idx));
    check_eq({tag, "_sel"}, 32'(u_if.sel), 32'(idx));
    check_eq({tag, "_mem_en"}, 32'(u_if.mem_en), 32'h1);
    check_eq({tag, "_addr"}, 32'(u_if.addr), 32'(exp_addr));
    check_eq({tag, "_done"}, 32'(u_if.done), 32'h0);
    check_eq({tag, "_err"}, 32'(u_if.err), 32'h0);
  endtask

  logic [15:0] exp_addr_tab [4];

  initial begin
    n_checks = 0;
    n_fails  = 0;
    exp_addr_tab[0] = 16'h1000;
    exp_addr_tab[1] = 16'h2000;
    exp_addr_tab[2] = 16'h3000;
    exp_addr_tab[3] = 16'h4000;

    // Reset held two cycles with every request and mem_rdy asserted.
    reset       = 1'b1;
    u_if.req     = 4'b1111;
    u_if.mem_rdy = 1'b1;
    u_if.a       = 16'h1000;
    u_if.b       = 16'h2000;
    u_if.c       = 16'h3000;
    u_if.d       = 16'h4000;
    @(negedge clk);
    step();
    step();
    check_idle("rst");
    check_eq("rst_sel", 32'(u_if.sel), 32'h0);
    check_eq("rst_done", 32'(u_if.done), 32'h0);
    check_eq("rst_err", 32'(u_if.err), 32'h0);

    // First arbitration after reset goes to requester 0; then abort it.
    reset        = 1'b0;
    u_if.mem_rdy = 1'b0;
    u_if.req     = 4'b1111;
    step();
    check_grant("first", 0, 16'h1000);
    u_if.req = 4'b0000;
    step();
    check_idle("first_abort");
    check_eq("first_abort_done", 32'(u_if.done), 32'h0);
    check_eq("first_abort_err", 32'(u_if.err), 32'h0);

    // Single request on requester 2, completion on the third grant cycle.
    u_if.req = 4'b0100;
    step();
    check_grant("single_c1", 2, 16'h3000);
    step();
    check_grant("single_c2", 2, 16'h3000);
    step();
    check_grant("single_c3", 2, 16'h3000);
    u_if.mem_rdy = 1'b1;
    step();
    check_idle("single_end");
    check_eq("single_done", 32'(u_if.done), 32'h1);
    check_eq("single_err", 32'(u_if.err), 32'h0);
    u_if.mem_rdy = 1'b0;
    u_if.req     = 4'b0000;
    step();
    check_eq("single_done_pulse", 32'(u_if.done), 32'h0);
    check_eq("single_sel_hold", 32'(u_if.sel), 32'h2);
    check_eq("single_addr_hold", 32'(u_if.addr), 32'h3000);
    u_if.c = 16'h3abc;
    #1;
    check_eq("addr_comb", 32'(u_if.addr), 32'h3abc);
    u_if.c = 16'h3000;

    // Fairness: reset so requester 0 leads, then all request with mem_rdy stuck high.
    reset = 1'b1;
    step();
    reset        = 1'b0;
    u_if.req     = 4'b1111;
    u_if.mem_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check_grant($sformatf("fair%0d", k), k % 4, exp_addr_tab[k % 4]);
      step();
      check_idle($sformatf("fair%0d_end", k));
      check_eq($sformatf("fair%0d_done", k), 32'(u_if.done), 32'h1);
    end
    u_if.req     = 4'b0000;
    u_if.mem_rdy = 1'b0;
    step();

    // Timeout on requester 1 (last grantee was 0).
    u_if.req = 4'b0010;
    for (int k = 1; k <= TIMEOUT; k++) begin
      step();
      check_grant($sformatf("to_c%0d", k), 1, 16'h2000);
    end
    step();
    check_idle("to_end");
    check_eq("to_err", 32'(u_if.err), 32'h1);
    check_eq("to_done", 32'(u_if.done), 32'h0);

    // Re-grant because req[1] is still high; mem_rdy arrives on the last allowed cycle.
    for (int k = 1; k <= TIMEOUT; k++) begin
      step();
      check_grant($sformatf("rg_c%0d", k), 1, 16'h2000);
    end
    u_if.mem_rdy = 1'b1;
    step();
    check_idle("rg_end");
    check_eq("rg_done", 32'(u_if.done), 32'h1);
    check_eq("rg_err", 32'(u_if.err), 32'h0);
    u_if.mem_rdy = 1'b0;
    u_if.req     = 4'b0000;
    step();

    // Abort: requester 3 wins over 0 (search starts at 2), drops after 2 cycles.
    u_if.req = 4'b1001;
    step();
    check_grant("ab_c1", 3, 16'h4000);
    step();
    check_grant("ab_c2", 3, 16'h4000);
    u_if.req = 4'b0001;
    step();
    check_idle("ab_end");
    check_eq("ab_done", 32'(u_if.done), 32'h0);
    check_eq("ab_err", 32'(u_if.err), 32'h0);
    step();
    check_grant("ab_next", 0, 16'h1000);
    u_if.req = 4'b0000;
    step();
    check_idle("ab_next_end");

    // Reset during a grant to requester 2 drops it; priority returns to requester 0.
    u_if.req = 4'b0100;
    step();
    check_grant("mr_grant", 2, 16'h3000);
    reset = 1'b1;
    step();
    check_idle("mr_rst");
    check_eq("mr_sel", 32'(u_if.sel), 32'h0);
    check_eq("mr_done", 32'(u_if.done), 32'h0);
    check_eq("mr_err", 32'(u_if.err), 32'h0);
    reset    = 1'b0;
    u_if.req = 4'b0101;
    step();
    check_grant("mr_next", 0, 16'h1000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
